e203_exu_flush_arb: RTL and testbench

Parametrised N-channel pipeline-flush arbiter for the EXU commit stage. It sits between the flush sources (exception/interrupt, branch-mispredict, fence.i/mret, and future sources) and the IFU flush interface. It replaces the fixed two-way combinational flush mux with a registered, priority-ordered request/acknowledge engine. It also provides optional preemption, a saturating flush counter, and an optional buffered BHT-update queue.

---
 rtl/e203_exu_flush_arb_if.sv | 28 ++
 rtl/e203_exu_flush_arb.sv | 168 ++++++++++++++++
 tb/tb_e203_exu_flush_arb.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/e203_exu_flush_arb_if.sv
// Flush handshake bundle between the commit-stage flush sources, the flush arbiter and the IFU.
interface e203_exu_flush_arb_if #(
    parameter int NCH     = 2,
    parameter int PC_SIZE = 32
);
    logic [NCH-1:0]         src_req;
    logic [NCH*PC_SIZE-1:0] src_op1;
    logic [NCH*PC_SIZE-1:0] src_op2;
    logic [NCH-1:0]         src_ack;
    logic                   pipe_flush_req;
    logic [PC_SIZE-1:0]     pipe_flush_add_op1;
    logic [PC_SIZE-1:0]     pipe_flush_add_op2;
    logic [NCH-1:0]         pipe_flush_src;
    logic                   pipe_flush_ack;
    logic                   flush_pulse;

    modport master (
        output src_req, src_op1, src_op2, pipe_flush_ack,
        input  src_ack, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
               pipe_flush_src, flush_pulse
    );

    modport slave (
        input  src_req, src_op1, src_op2, pipe_flush_ack,
        output src_ack, pipe_flush_req, pipe_flush_add_op1, pipe_flush_add_op2,
               pipe_flush_src, flush_pulse
    );
endinterface

// File: rtl/e203_exu_flush_arb.sv
// Priority flush arbiter (channel 0 highest) with optional preemption and a saturating flush counter.
// Define E203_FLUSH_ARB_BQ_EN to add the buffered BHT-update queue.
module e203_exu_flush_arb #(
    parameter int NCH      = 2,
    parameter int PC_SIZE  = 32,
    parameter int CNT_W    = 16,
    parameter int PREEMPT  = 1,
    parameter int BQ_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    e203_exu_flush_arb_if.slave  fl,
    input  logic                 cnt_clr_i,
    output logic [CNT_W-1:0]     flush_cnt_o
`ifdef E203_FLUSH_ARB_BQ_EN
    ,
    input  logic                 bq_wr_vld_i,
    input  logic                 bq_wr_taken_i,
    input  logic [PC_SIZE-1:0]   bq_wr_pc_i,
    input  logic                 bq_rd_rdy_i,
    output logic                 bq_rd_vld_o,
    output logic                 bq_rd_taken_o,
    output logic [PC_SIZE-1:0]   bq_rd_pc_o,
    output logic                 bq_full_o,
    output logic [7:0]           bq_drop_cnt_o
`endif
);

    if (BQ_DEPTH < 2 || (BQ_DEPTH & (BQ_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("BQ_DEPTH must be a power of two and at least 2");
    end

    typedef enum logic {IDLE, REQ} state_e;

    state_e             state_q, state_d;
    logic [NCH-1:0]     grant_q, grant_d;
    logic [PC_SIZE-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]     pick;
    logic [PC_SIZE-1:0] pick_op1, pick_op2;
    logic [NCH-1:0]     ack;
    logic               pulse;

    // Descending scan so the lowest-indexed requester is the last (winning) hit.
    always_comb begin
        pick     = '0;
        pick_op1 = '0;
        pick_op2 = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (fl.src_req[i]) begin
                pick     = '0;
                pick[i]  = 1'b1;
                pick_op1 = fl.src_op1[i*PC_SIZE +: PC_SIZE];
                pick_op2 = fl.src_op2[i*PC_SIZE +: PC_SIZE];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        ack     = '0;
        pulse   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|fl.src_req) begin
                    state_d = REQ;
                    grant_d = pick;
                    op1_d   = pick_op1;
                    op2_d   = pick_op2;
                end
            end
            REQ: begin
                if (fl.pipe_flush_ack) begin
                    ack     = grant_q;
                    pulse   = 1'b1;
                    grant_d = '0;
                    state_d = IDLE;
                end else if ((PREEMPT != 0) && !grant_q[0] && fl.src_req[0]) begin
                    grant_d = NCH'(1);
                    op1_d   = fl.src_op1[PC_SIZE-1:0];
                    op2_d   = fl.src_op2[PC_SIZE-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (pulse && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fl.pipe_flush_req     = (state_q == REQ);
    assign fl.pipe_flush_src     = grant_q;
    assign fl.pipe_flush_add_op1 = op1_q;
    assign fl.pipe_flush_add_op2 = op2_q;
    assign fl.src_ack            = ack;
    assign fl.flush_pulse        = pulse;
    assign flush_cnt_o           = cnt_q;

`ifdef E203_FLUSH_ARB_BQ_EN
    localparam int BQ_AW = $clog2(BQ_DEPTH);

    logic [PC_SIZE-1:0]  bq_pc_q [BQ_DEPTH];
    logic [BQ_DEPTH-1:0] bq_taken_q;
    logic [BQ_AW-1:0]    bq_wptr_q, bq_rptr_q;
    logic [BQ_AW:0]      bq_count_q;
    logic [7:0]          bq_drop_q;
    logic                bq_vld, bq_push, bq_pop;

    assign bq_vld    = (bq_count_q != '0);
    assign bq_full_o = (bq_count_q == (BQ_AW+1)'(BQ_DEPTH));
    assign bq_pop    = bq_vld & bq_rd_rdy_i;
    // A pop frees the slot in the same cycle, so a full queue still accepts a push alongside it.
    assign bq_push   = bq_wr_vld_i & (~bq_full_o | bq_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bq_wptr_q  <= '0;
            bq_rptr_q  <= '0;
            bq_count_q <= '0;
            bq_drop_q  <= '0;
        end else begin
            if (bq_push) bq_wptr_q <= bq_wptr_q + BQ_AW'(1);
            if (bq_pop)  bq_rptr_q <= bq_rptr_q + BQ_AW'(1);
            if (bq_push && !bq_pop) bq_count_q <= bq_count_q + (BQ_AW+1)'(1);
            else if (!bq_push && bq_pop) bq_count_q <= bq_count_q - (BQ_AW+1)'(1);
            if (bq_wr_vld_i && !bq_push && (bq_drop_q != 8'hFF)) bq_drop_q <= bq_drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (bq_push) begin
            bq_pc_q[bq_wptr_q]    <= bq_wr_pc_i;
            bq_taken_q[bq_wptr_q] <= bq_wr_taken_i;
        end
    end

    assign bq_rd_vld_o   = bq_vld;
    assign bq_rd_pc_o    = bq_vld ? bq_pc_q[bq_rptr_q] : '0;
    assign bq_rd_taken_o = bq_vld & bq_taken_q[bq_rptr_q];
    assign bq_drop_cnt_o = bq_drop_q;
`endif

endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// Self-checking bench for e203_exu_flush_arb: vector table, hand sequences and a random run against a reference model.
module tb_e203_exu_flush_arb;
    localparam int CW = 4;
    localparam logic [31:0] C0_OP1 = 32'h8000_0000, C0_OP2 = 32'h0000_0010;
    localparam logic [31:0] C1_OP1 = 32'h2000_0100, C1_OP2 = 32'h0000_0024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    e203_exu_flush_arb_if #(.NCH(2), .PC_SIZE(32)) fa ();
    e203_exu_flush_arb_if #(.NCH(2), .PC_SIZE(32)) fb ();

    logic          a_clr, b_clr;
    logic [CW-1:0] a_cnt;
    logic [15:0]   b_cnt;

`ifdef E203_FLUSH_ARB_BQ_EN
    logic        q_wv, q_wt, q_rr, q_rv, q_rt, q_full;
    logic [31:0] q_wpc, q_rpc;
    logic [7:0]  q_drop;
    logic        n_rv, n_rt, n_full;
    logic [31:0] n_rpc;
    logic [7:0]  n_drop;
`endif

    e203_exu_flush_arb #(.NCH(2), .PC_SIZE(32), .CNT_W(CW), .PREEMPT(1), .BQ_DEPTH(4)) u_dut (
        .clk(clk), .rst(rst), .fl(fa), .cnt_clr_i(a_clr), .flush_cnt_o(a_cnt)
`ifdef E203_FLUSH_ARB_BQ_EN
        , .bq_wr_vld_i(q_wv), .bq_wr_taken_i(q_wt), .bq_wr_pc_i(q_wpc), .bq_rd_rdy_i(q_rr),
        .bq_rd_vld_o(q_rv), .bq_rd_taken_o(q_rt), .bq_rd_pc_o(q_rpc), .bq_full_o(q_full),
        .bq_drop_cnt_o(q_drop)
`endif
    );

    e203_exu_flush_arb #(.NCH(2), .PC_SIZE(32), .CNT_W(16), .PREEMPT(0), .BQ_DEPTH(4)) u_np (
        .clk(clk), .rst(rst), .fl(fb), .cnt_clr_i(b_clr), .flush_cnt_o(b_cnt)
`ifdef E203_FLUSH_ARB_BQ_EN
        , .bq_wr_vld_i(1'b0), .bq_wr_taken_i(1'b0), .bq_wr_pc_i(32'h0), .bq_rd_rdy_i(1'b0),
        .bq_rd_vld_o(n_rv), .bq_rd_taken_o(n_rt), .bq_rd_pc_o(n_rpc), .bq_full_o(n_full),
        .bq_drop_cnt_o(n_drop)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        ack;
        logic        clr;
        logic        e_req;
        logic [1:0]  e_src;
        logic [1:0]  e_ack;
        logic [3:0]  e_cnt;
        logic [31:0] e_op1;
        logic [31:0] e_op2;
    } vec_t;

    vec_t vecs[24];

    // reference model state
    bit          pend[2];
    logic [31:0] r_op1[2], r_op2[2];
    bit          m_busy;
    int          m_g;
    logic [31:0] m_op1, m_op2;
    int          m_cnt;
    logic [1:0]  e_ack;

    initial begin
        rst = 1'b1;
        a_clr = 1'b0; b_clr = 1'b0;
        fa.src_req = '0; fa.pipe_flush_ack = 1'b0;
        fb.src_req = '0; fb.pipe_flush_ack = 1'b0;
        fa.src_op1 = {C1_OP1, C0_OP1}; fa.src_op2 = {C1_OP2, C0_OP2};
        fb.src_op1 = {C1_OP1, C0_OP1}; fb.src_op2 = {C1_OP2, C0_OP2};
`ifdef E203_FLUSH_ARB_BQ_EN
        q_wv = 1'b0; q_wt = 1'b0; q_wpc = '0; q_rr = 1'b0;
`endif
        //         req    ack  clr   e_req e_src  e_ack  cnt   op1     op2
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 32'h0,  32'h0};
        vecs[1]  = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 32'h0,  32'h0};
        vecs[2]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 4'd0, C0_OP1, C0_OP2};
        vecs[3]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 4'd0, C0_OP1, C0_OP2};
        vecs[4]  = '{2'b01, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 4'd0, C0_OP1, C0_OP2};
        vecs[5]  = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 4'd0, C0_OP1, C0_OP2};
        vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd1, 32'h0,  32'h0};
        vecs[7]  = '{2'b11, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd1, 32'h0,  32'h0};
        vecs[8]  = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 4'd1, C0_OP1, C0_OP2};
        vecs[9]  = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd2, 32'h0,  32'h0};
        vecs[10] = '{2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'd2, C1_OP1, C1_OP2};
        vecs[11] = '{2'b10, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 4'd2, C1_OP1, C1_OP2};
        vecs[12] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd3, 32'h0,  32'h0};
        vecs[13] = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd3, 32'h0,  32'h0};
        vecs[14] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'd3, C1_OP1, C1_OP2};
        vecs[15] = '{2'b11, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 4'd3, C0_OP1, C0_OP2};
        vecs[16] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 4'd3, C0_OP1, C0_OP2};
        vecs[17] = '{2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd4, 32'h0,  32'h0};
        vecs[18] = '{2'b10, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 4'd4, C1_OP1, C1_OP2};
        vecs[19] = '{2'b11, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 4'd4, C1_OP1, C1_OP2};
        vecs[20] = '{2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd5, 32'h0,  32'h0};
        vecs[21] = '{2'b01, 1'b1, 1'b0, 1'b1, 2'b01, 2'b01, 4'd5, C0_OP1, C0_OP2};
        vecs[22] = '{2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 4'd6, 32'h0,  32'h0};
        vecs[23] = '{2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 4'd0, 32'h0,  32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req",   64'(fa.pipe_flush_req), 64'(0));
        chk("rst_src",   64'(fa.pipe_flush_src), 64'(0));
        chk("rst_op1",   64'(fa.pipe_flush_add_op1), 64'(0));
        chk("rst_ack",   64'(fa.src_ack), 64'(0));
        chk("rst_cnt",   64'(a_cnt), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        for (int v = 0; v < 24; v++) begin
            fa.src_req = vecs[v].req;
            fa.pipe_flush_ack = vecs[v].ack;
            a_clr = vecs[v].clr;
            @(negedge clk);
            chk($sformatf("vec%0d_req", v), 64'(fa.pipe_flush_req), 64'(vecs[v].e_req));
            chk($sformatf("vec%0d_src", v), 64'(fa.pipe_flush_src), 64'(vecs[v].e_src));
            chk($sformatf("vec%0d_ack", v), 64'(fa.src_ack), 64'(vecs[v].e_ack));
            chk($sformatf("vec%0d_pulse", v), 64'(fa.flush_pulse), 64'(|vecs[v].e_ack));
            chk($sformatf("vec%0d_cnt", v), 64'(a_cnt), 64'(vecs[v].e_cnt));
            if (vecs[v].e_req) begin
                chk($sformatf("vec%0d_op1", v), 64'(fa.pipe_flush_add_op1), 64'(vecs[v].e_op1));
                chk($sformatf("vec%0d_op2", v), 64'(fa.pipe_flush_add_op2), 64'(vecs[v].e_op2));
            end
            tick();
        end
        fa.src_req = '0; fa.pipe_flush_ack = 1'b0; a_clr = 1'b0;

        // no preemption: channel 1 keeps its grant until acked
        fb.src_req = 2'b10; tick();
        fb.src_req = 2'b11;
        @(negedge clk);
        chk("np_src_a", 64'(fb.pipe_flush_src), 64'(2'b10));
        tick();
        @(negedge clk);
        chk("np_src_b", 64'(fb.pipe_flush_src), 64'(2'b10));
        chk("np_op1",   64'(fb.pipe_flush_add_op1), 64'(C1_OP1));
        chk("np_ack_b", 64'(fb.src_ack), 64'(0));
        tick();
        fb.pipe_flush_ack = 1'b1;
        @(negedge clk);
        chk("np_ack", 64'(fb.src_ack), 64'(2'b10));
        tick();
        fb.pipe_flush_ack = 1'b0; fb.src_req = 2'b01;
        @(negedge clk);
        chk("np_bubble", 64'(fb.pipe_flush_req), 64'(0));
        tick();
        @(negedge clk);
        chk("np_src_c", 64'(fb.pipe_flush_src), 64'(2'b01));
        chk("np_op1_c", 64'(fb.pipe_flush_add_op1), 64'(C0_OP1));
        tick();
        fb.pipe_flush_ack = 1'b1; tick();
        fb.pipe_flush_ack = 1'b0; fb.src_req = '0; tick();
        chk("np_cnt", 64'(b_cnt), 64'(2));

        // counter saturation and clear-beats-increment
        for (int k = 0; k < 16; k++) begin
            fa.src_req = 2'b01; tick();
            fa.pipe_flush_ack = 1'b1; tick();
            fa.pipe_flush_ack = 1'b0; fa.src_req = '0; tick();
            if (k == 14) chk("cnt_at_max", 64'(a_cnt), 64'(15));
        end
        chk("cnt_sat", 64'(a_cnt), 64'(15));
        fa.src_req = 2'b01; tick();
        fa.pipe_flush_ack = 1'b1; a_clr = 1'b1;
        @(negedge clk);
        chk("clr_pulse", 64'(fa.flush_pulse), 64'(1));
        tick();
        fa.pipe_flush_ack = 1'b0; a_clr = 1'b0; fa.src_req = '0;
        @(negedge clk);
        chk("clr_cnt", 64'(a_cnt), 64'(0));
        tick();

`ifdef E203_FLUSH_ARB_BQ_EN
        @(negedge clk);
        chk("bq_empty", 64'(q_rv), 64'(0));
        q_wv = 1'b1; q_wpc = 32'h100; q_wt = 1'b1; q_rr = 1'b1;
        @(negedge clk);
        chk("bq_emp_pp_vld", 64'(q_rv), 64'(0));
        tick();
        q_wv = 1'b0; q_rr = 1'b0;
        @(negedge clk);
        chk("bq_emp_pp_pc", 64'(q_rpc), 64'(32'h100));
        q_rr = 1'b1; tick(); q_rr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            q_wv = 1'b1; q_wpc = 32'h200 + 32'(k * 4); q_wt = k[0];
            tick();
        end
        q_wv = 1'b0;
        @(negedge clk);
        chk("bq_full", 64'(q_full), 64'(1));
        chk("bq_drop", 64'(q_drop), 64'(1));
        q_wv = 1'b1; q_wpc = 32'h300; q_wt = 1'b0; q_rr = 1'b1;
        tick();
        q_wv = 1'b0; q_rr = 1'b0;
        @(negedge clk);
        chk("bq_full_pp", 64'(q_full), 64'(1));
        chk("bq_drop_pp", 64'(q_drop), 64'(1));
        for (int k = 0; k < 4; k++) begin
            logic [31:0] epc;
            epc = (k == 3) ? 32'h300 : 32'h204 + 32'(k * 4);
            @(negedge clk);
            chk($sformatf("bq_pop%0d_pc", k), 64'(q_rpc), 64'(epc));
            chk($sformatf("bq_pop%0d_t", k), 64'(q_rt), 64'((k == 0 || k == 2) ? 1 : 0));
            q_rr = 1'b1; tick(); q_rr = 1'b0;
        end
        @(negedge clk);
        chk("bq_drained", 64'(q_rv), 64'(0));
        tick();
`endif

        // asynchronous reset in the middle of a request
        fa.src_req = 2'b01; tick();
        @(negedge clk);
        chk("mid_req", 64'(fa.pipe_flush_req), 64'(1));
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 64'(fa.pipe_flush_req), 64'(0));
        chk("arst_src", 64'(fa.pipe_flush_src), 64'(0));
        chk("arst_ack", 64'(fa.src_ack), 64'(0));
        fa.src_req = '0;
        tick();
        rst = 1'b0;

        // random run against the reference model
        pend[0] = 0; pend[1] = 0; m_busy = 0; m_g = 0; m_cnt = 0;
        m_op1 = '0; m_op2 = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && $urandom_range(3) == 0) begin
                    pend[c] = 1; r_op1[c] = $urandom; r_op2[c] = $urandom;
                end
            end
            fa.src_req = {pend[1], pend[0]};
            fa.src_op1 = {r_op1[1], r_op1[0]};
            fa.src_op2 = {r_op2[1], r_op2[0]};
            fa.pipe_flush_ack = ($urandom_range(2) == 0);
            a_clr = ($urandom_range(63) == 0);
            @(negedge clk);
            e_ack = (m_busy && fa.pipe_flush_ack) ? 2'(1 << m_g) : 2'b00;
            chk("rnd_req", 64'(fa.pipe_flush_req), 64'(m_busy));
            chk("rnd_src", 64'(fa.pipe_flush_src), m_busy ? 64'(1 << m_g) : 64'(0));
            chk("rnd_ack", 64'(fa.src_ack), 64'(e_ack));
            chk("rnd_pulse", 64'(fa.flush_pulse), 64'(e_ack != 0));
            chk("rnd_cnt", 64'(a_cnt), 64'(m_cnt));
            if (m_busy) begin
                chk("rnd_op1", 64'(fa.pipe_flush_add_op1), 64'(m_op1));
                chk("rnd_op2", 64'(fa.pipe_flush_add_op2), 64'(m_op2));
            end
            @(posedge clk);
            if (a_clr) m_cnt = 0;
            else if (e_ack != 0 && m_cnt < (1 << CW) - 1) m_cnt++;
            if (m_busy) begin
                if (fa.pipe_flush_ack) begin
                    m_busy = 0; pend[m_g] = 0;
                end else if (m_g != 0 && pend[0]) begin
                    m_g = 0; m_op1 = r_op1[0]; m_op2 = r_op2[0];
                end
            end else if (pend[0] || pend[1]) begin
                m_g = pend[0] ? 0 : 1;
                m_busy = 1; m_op1 = r_op1[m_g]; m_op2 = r_op2[m_g];
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
